// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared exmemory port: req/ack handshake,
// round-robin on ties, fixed-latency strobe sequencing, registered read data.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;
  logic [AW-1:0] win_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    // On a tie the requester not served last wins; otherwise whoever asks.
    win         = (req0 && req1) ? ~last_gnt_q : req1;
    win_addr    = win ? addr1 : addr0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d       = win;
          last_gnt_d  = win;
          we_d        = win ? we1 : we0;
          mem_addr_d  = win_addr;
          mem_wdata_d = win ? wdata1 : wdata0;
          if (win_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            cnt_d   = LAT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (!we_q) rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads strobe for the whole latency window; writes strobe once on entry.
  assign mem_read  = (state_q == BUSY) && !we_q;
  assign mem_write = (state_q == BUSY) && we_q && (cnt_q == LAT);
  assign ack0      = (state_q == DONE) && !gnt_q;
  assign ack1      = (state_q == DONE) &&  gnt_q;
  assign err0      = ack0 && err_q;
  assign err1      = ack1 && err_q;
  assign busy      = (state_q != IDLE);
  assign gnt       = gnt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one instance at MEM_LAT=1, one at
// MEM_LAT=3, each with its own behavioural memory and LED register.
module tb_mem_bus_arbiter;

  typedef struct {
    bit          r;
    bit          we;
    bit          err;
    logic [31:0] rd;
    int          nrd;
    int          nwr;
    logic [31:0] addr;
    logic [31:0] wd;
  } item_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_v, req0_v, we0_v, req1_v, we1_v;
  logic [1:0]  ack0_v, err0_v, ack1_v, err1_v, mem_read_v, mem_write_v, gnt_v, busy_v;
  logic [31:0] addr0_v[2], wdata0_v[2], addr1_v[2], wdata1_v[2];
  logic [31:0] rdata_v[2], mem_addr_v[2], mem_wdata_v[2], mem_rdata_v[2];

  logic [31:0] mem0[256], mem1[256];
  logic [15:0] leds0, leds1;
  int          rd_cnt[2], wr_cnt[2];
  int          n_vec = 0, n_err = 0;
  item_t       q0[$], q1[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut0 (
    .clk(clk), .reset(rst_v[0]),
    .req0(req0_v[0]), .we0(we0_v[0]), .addr0(addr0_v[0]), .wdata0(wdata0_v[0]),
    .ack0(ack0_v[0]), .err0(err0_v[0]),
    .req1(req1_v[0]), .we1(we1_v[0]), .addr1(addr1_v[0]), .wdata1(wdata1_v[0]),
    .ack1(ack1_v[0]), .err1(err1_v[0]),
    .rdata(rdata_v[0]), .mem_read(mem_read_v[0]), .mem_write(mem_write_v[0]),
    .mem_addr(mem_addr_v[0]), .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0]),
    .gnt(gnt_v[0]), .busy(busy_v[0]));

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut1 (
    .clk(clk), .reset(rst_v[1]),
    .req0(req0_v[1]), .we0(we0_v[1]), .addr0(addr0_v[1]), .wdata0(wdata0_v[1]),
    .ack0(ack0_v[1]), .err0(err0_v[1]),
    .req1(req1_v[1]), .we1(we1_v[1]), .addr1(addr1_v[1]), .wdata1(wdata1_v[1]),
    .ack1(ack1_v[1]), .err1(err1_v[1]),
    .rdata(rdata_v[1]), .mem_read(mem_read_v[1]), .mem_write(mem_write_v[1]),
    .mem_addr(mem_addr_v[1]), .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1]),
    .gnt(gnt_v[1]), .busy(busy_v[1]));

  // Read data drifts by one per elapsed strobe cycle, so only a capture in the
  // last strobe cycle yields word + MEM_LAT - 1.
  assign mem_rdata_v[0] = mem0[mem_addr_v[0][9:2]] + ((rd_cnt[0] > 0) ? 32'(rd_cnt[0] - 1) : 32'd0);
  assign mem_rdata_v[1] = mem1[mem_addr_v[1][9:2]] + ((rd_cnt[1] > 0) ? 32'(rd_cnt[1] - 1) : 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic item_t mk(input int d, input bit r, input bit we,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd);
    item_t it;
    bit    mis;
    mis     = (a[1:0] != 2'b00);
    it.r    = r;
    it.we   = we;
    it.err  = mis;
    it.rd   = rd;
    it.nrd  = (mis || we) ? 0 : ((d == 1) ? 3 : 1);
    it.nwr  = (!mis && we) ? 1 : 0;
    it.addr = a;
    it.wd   = wd;
    return it;
  endfunction

  task automatic push_item(input int d, input item_t it);
    if (d == 0) q0.push_back(it);
    else        q1.push_back(it);
  endtask

  // Issue one transaction and hold it until ack; exp_lat > 0 checks edges to ack.
  task automatic txn(input int d, input bit r, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input bit push, input int exp_lat);
    int n;
    bit got;
    if (push) push_item(d, mk(d, r, we, a, wd, rd));
    if (!r) begin
      we0_v[d] = we; addr0_v[d] = a; wdata0_v[d] = wd; req0_v[d] = 1'b1;
    end else begin
      we1_v[d] = we; addr1_v[d] = a; wdata1_v[d] = wd; req1_v[d] = 1'b1;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      got = r ? ack1_v[d] : ack0_v[d];
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    else if (exp_lat > 0) chk("ack_latency", 32'(n), 32'(exp_lat));
    if (!r) req0_v[d] = 1'b0;
    else    req1_v[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst(input int d);
    rst_v[d] = 1'b1;
    @(posedge clk); #1;
    rst_v[d] = 1'b0;
  endtask

  // Monitor and memory model, both on the falling edge away from DUT updates.
  initial begin
    item_t it;
    bit    empty;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    mem0[8'h10] = 32'hDEADBEEF;
    mem1[8'h20] = 32'h12345670;
    leds0 = 16'h0;
    leds1 = 16'h0;
    rd_cnt[0] = 0; rd_cnt[1] = 0; wr_cnt[0] = 0; wr_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_v[d] !== 1'b0) begin
          rd_cnt[d] = 0;
          wr_cnt[d] = 0;
        end else begin
          if (mem_read_v[d]) rd_cnt[d]++;
          if (mem_write_v[d]) begin
            wr_cnt[d]++;
            if (mem_addr_v[d] == 32'hFFFF0004) begin
              if (d == 0) leds0 = mem_wdata_v[d][15:0];
              else        leds1 = mem_wdata_v[d][15:0];
            end else if (mem_addr_v[d] < 32'hFFFF0000) begin
              if (d == 0) mem0[mem_addr_v[d][9:2]] = mem_wdata_v[d];
              else        mem1[mem_addr_v[d][9:2]] = mem_wdata_v[d];
            end
          end
          if (ack0_v[d] || ack1_v[d]) begin
            chk("ack_exclusive", 32'(ack0_v[d] & ack1_v[d]), 32'd0);
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) chk("unexpected_ack", 32'd1, 32'd0);
            else begin
              it = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk("ack_requester", 32'(ack1_v[d]), 32'(it.r));
              chk("gnt",           32'(gnt_v[d]),  32'(it.r));
              chk("busy_in_done",  32'(busy_v[d]), 32'd1);
              chk("err", 32'(it.r ? err1_v[d] : err0_v[d]), 32'(it.err));
              chk("rdata",         rdata_v[d],     it.rd);
              chk("read_cycles",   32'(rd_cnt[d]), 32'(it.nrd));
              chk("write_cycles",  32'(wr_cnt[d]), 32'(it.nwr));
              chk("mem_addr",      mem_addr_v[d],  it.addr);
              if (it.we) chk("mem_wdata", mem_wdata_v[d], it.wd);
            end
            rd_cnt[d] = 0;
            wr_cnt[d] = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 2'b11;
    req0_v = '0; we0_v = '0; req1_v = '0; we1_v = '0;
    for (int d = 0; d < 2; d++) begin
      addr0_v[d] = '0; wdata0_v[d] = '0; addr1_v[d] = '0; wdata1_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy",   32'(busy_v[d]), 32'd0);
      chk("rst_gnt",    32'(gnt_v[d]),  32'd0);
      chk("rst_ackerr", 32'({ack0_v[d], ack1_v[d], err0_v[d], err1_v[d]}), 32'd0);
      chk("rst_strobe", 32'({mem_read_v[d], mem_write_v[d]}), 32'd0);
      chk("rst_addr",   mem_addr_v[d],  32'd0);
      chk("rst_wdata",  mem_wdata_v[d], 32'd0);
      chk("rst_rdata",  rdata_v[d],     32'd0);
    end
    rst_v = 2'b00;

    // MEM_LAT = 1
    txn(0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEADBEEF, 1'b1, 2);
    txn(0, 1'b1, 1'b1, 32'hFFFF_0004, 32'h0000_A5A5, 32'hDEADBEEF, 1'b1, 2);
    chk("leds", 32'(leds0), 32'h0000_A5A5);
    txn(0, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 32'hDEADBEEF, 1'b1, 1);

    pulse_rst(0);
    push_item(0, mk(0, 1'b0, 1'b0, 32'h40,  32'h0,         32'hDEADBEEF));
    push_item(0, mk(0, 1'b1, 1'b1, 32'h100, 32'h1111_1111, 32'hDEADBEEF));
    push_item(0, mk(0, 1'b0, 1'b0, 32'h100, 32'h0,         32'h1111_1111));
    push_item(0, mk(0, 1'b1, 1'b1, 32'h104, 32'h2222_2222, 32'h1111_1111));
    fork
      begin
        txn(0, 1'b0, 1'b0, 32'h40,  32'h0, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0);
      end
      begin
        txn(0, 1'b1, 1'b1, 32'h100, 32'h1111_1111, 32'h0, 1'b0, 0);
        txn(0, 1'b1, 1'b1, 32'h104, 32'h2222_2222, 32'h0, 1'b0, 0);
      end
    join
    chk("mem_104", mem0[8'h41], 32'h2222_2222);

    // MEM_LAT = 3
    txn(1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5672, 1'b1, 4);
    txn(1, 1'b1, 1'b1, 32'h0000_0084, 32'hCAFE_0000, 32'h1234_5672, 1'b1, 4);
    chk("mem_84", mem1[8'h21], 32'hCAFE_0000);
    txn(1, 1'b1, 1'b1, 32'h0000_0087, 32'hFFFF_FFFF, 32'h1234_5672, 1'b1, 1);

    // Abort a read in its second strobe cycle.
    we0_v[1] = 1'b0; addr0_v[1] = 32'h80; req0_v[1] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_reset_read", 32'(mem_read_v[1]), 32'd1);
    rst_v[1] = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy",   32'(busy_v[1]), 32'd0);
    chk("abort_strobe", 32'({mem_read_v[1], mem_write_v[1]}), 32'd0);
    chk("abort_ack",    32'({ack0_v[1], ack1_v[1]}), 32'd0);
    req0_v[1] = 1'b0;
    @(posedge clk); #1;
    rst_v[1] = 1'b0;

    push_item(1, mk(1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h1234_5672));
    push_item(1, mk(1, 1'b1, 1'b0, 32'h84, 32'h0, 32'hCAFE_0002));
    fork
      txn(1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 0);
      txn(1, 1'b1, 1'b0, 32'h84, 32'h0, 32'h0, 1'b0, 0);
    join

    repeat (3) @(posedge clk);
    #1;
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
